// File: rtl/pipe5_fwd_core_if.sv
// Core-side bundle for pipe5_fwd_core: instruction fetch port, retire port,
// pipeline hold request and interlock status.
interface pipe5_fwd_core_if #(
  parameter int DW   = 8,
  parameter int RAW  = 3,
  parameter int IMMW = 7,
  parameter int PCW  = 8
);
  localparam int IW = 4 + 3*RAW + IMMW;

  logic            hold;
  logic [PCW-1:0]  imem_addr;
  logic [IW-1:0]   imem_data;
  logic            wb_valid;
  logic [RAW-1:0]  wb_rd;
  logic [DW-1:0]   wb_data;
  logic            stall;

  modport master (
    input  hold, imem_data,
    output imem_addr, wb_valid, wb_rd, wb_data, stall
  );

  modport slave (
    output hold, imem_data,
    input  imem_addr, wb_valid, wb_rd, wb_data, stall
  );
endinterface

// File: rtl/pipe5_fwd_core.sv
// Five-stage IF/ID/EX/MEM/WB integer pipeline with EX/MEM and MEM/WB operand
// forwarding, a one-cycle load-use interlock, internal regfile and data memory.
module pipe5_fwd_core #(
  parameter int DW   = 8,
  parameter int RAW  = 3,
  parameter int IMMW = 7,
  parameter int PCW  = 8,
  parameter int DMAW = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipe5_fwd_core_if.master bus
);
  localparam int IW   = 4 + 3*RAW + IMMW;
  localparam int NREG = 2**RAW;
  localparam int NMEM = 2**DMAW;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
    OP_XOR = 4'd5, OP_ADDI = 4'd6, OP_LD = 4'd7, OP_ST = 4'd8
  } op_e;

  logic [PCW-1:0] pc;
  logic [IW-1:0]  ifid_instr;
  logic [DW-1:0]  rf   [NREG];
  logic [DW-1:0]  dmem [NMEM];

  op_e            idex_op;
  logic [RAW-1:0] idex_rs, idex_rt, idex_rd;
  logic [DW-1:0]  idex_rs_val, idex_rt_val, idex_simm;
  logic           idex_wr, idex_ld, idex_st;

  logic           exmem_wr, exmem_ld, exmem_st;
  logic [RAW-1:0] exmem_rd;
  logic [DW-1:0]  exmem_alu, exmem_stdata;

  logic           memwb_wr;
  logic [RAW-1:0] memwb_rd;
  logic [DW-1:0]  memwb_data;

  logic [3:0]     id_raw_op;
  op_e            id_op;
  logic [RAW-1:0] id_rs, id_rt, id_rd;
  logic [IMMW-1:0] id_imm;
  logic [DW-1:0]  id_simm, id_rs_val, id_rt_val;
  logic           id_wr, id_use_rs, id_use_rt, load_use, stall;

  logic [DW-1:0]  ex_a, ex_b, ex_res;
  logic [DMAW-1:0] mem_addr;
  logic [DW-1:0]  mem_result;

  assign id_raw_op = ifid_instr[IW-1 -: 4];
  assign id_rs     = ifid_instr[IW-5 -: RAW];
  assign id_rt     = ifid_instr[IW-5-RAW -: RAW];
  assign id_rd     = ifid_instr[IMMW +: RAW];
  assign id_imm    = ifid_instr[IMMW-1:0];
  assign id_simm   = DW'($signed(id_imm));

  // Decode, regfile read with WB write-through, and load-use detection.
  always_comb begin
    id_op = OP_NOP;
    if (id_raw_op <= 4'd8) id_op = op_e'(id_raw_op);
    id_wr     = (id_op inside {[OP_ADD:OP_LD]}) && (id_rd != '0);
    id_use_rs = (id_op != OP_NOP);
    id_use_rt = (id_op inside {[OP_ADD:OP_XOR], OP_ST});
    id_rs_val = rf[id_rs];
    id_rt_val = rf[id_rt];
    if (memwb_wr && memwb_rd == id_rs) id_rs_val = memwb_data;
    if (memwb_wr && memwb_rd == id_rt) id_rt_val = memwb_data;
    load_use = idex_ld && ((id_use_rs && id_rs == idex_rd) ||
                           (id_use_rt && id_rt == idex_rd));
    stall = load_use && !bus.hold;
  end

  // Operand forwarding: later assignments take priority, so EX/MEM beats MEM/WB.
  // A load in EX/MEM has no data yet; the interlock guarantees nobody needs it.
  always_comb begin
    ex_a = idex_rs_val;
    ex_b = idex_rt_val;
    if (memwb_wr && memwb_rd == idex_rs) ex_a = memwb_data;
    if (memwb_wr && memwb_rd == idex_rt) ex_b = memwb_data;
    if (exmem_wr && !exmem_ld && exmem_rd == idex_rs) ex_a = exmem_alu;
    if (exmem_wr && !exmem_ld && exmem_rd == idex_rt) ex_b = exmem_alu;
    case (idex_op)
      OP_ADD:                ex_res = ex_a + ex_b;
      OP_SUB:                ex_res = ex_a - ex_b;
      OP_AND:                ex_res = ex_a & ex_b;
      OP_OR:                 ex_res = ex_a | ex_b;
      OP_XOR:                ex_res = ex_a ^ ex_b;
      OP_ADDI, OP_LD, OP_ST: ex_res = ex_a + idex_simm;
      default:               ex_res = '0;
    endcase
  end

  assign mem_addr   = exmem_alu[DMAW-1:0];
  assign mem_result = exmem_ld ? dmem[mem_addr] : exmem_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      ifid_instr   <= '0;
      idex_op      <= OP_NOP;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
      idex_rs_val  <= '0;
      idex_rt_val  <= '0;
      idex_simm    <= '0;
      idex_wr      <= 1'b0;
      idex_ld      <= 1'b0;
      idex_st      <= 1'b0;
      exmem_wr     <= 1'b0;
      exmem_ld     <= 1'b0;
      exmem_st     <= 1'b0;
      exmem_rd     <= '0;
      exmem_alu    <= '0;
      exmem_stdata <= '0;
      memwb_wr     <= 1'b0;
      memwb_rd     <= '0;
      memwb_data   <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      for (int i = 0; i < NMEM; i++) dmem[i] <= '0;
    end else if (!bus.hold) begin
      if (stall) begin
        idex_op     <= OP_NOP;
        idex_rs     <= '0;
        idex_rt     <= '0;
        idex_rd     <= '0;
        idex_rs_val <= '0;
        idex_rt_val <= '0;
        idex_simm   <= '0;
        idex_wr     <= 1'b0;
        idex_ld     <= 1'b0;
        idex_st     <= 1'b0;
      end else begin
        pc          <= pc + PCW'(1);
        ifid_instr  <= bus.imem_data;
        idex_op     <= id_op;
        idex_rs     <= id_rs;
        idex_rt     <= id_rt;
        idex_rd     <= id_rd;
        idex_rs_val <= id_rs_val;
        idex_rt_val <= id_rt_val;
        idex_simm   <= id_simm;
        idex_wr     <= id_wr;
        idex_ld     <= id_wr && (id_op == OP_LD);
        idex_st     <= (id_op == OP_ST);
      end
      exmem_wr     <= idex_wr;
      exmem_ld     <= idex_ld;
      exmem_st     <= idex_st;
      exmem_rd     <= idex_rd;
      exmem_alu    <= ex_res;
      exmem_stdata <= ex_b;
      memwb_wr     <= exmem_wr;
      memwb_rd     <= exmem_rd;
      memwb_data   <= mem_result;
      if (exmem_st) dmem[mem_addr] <= exmem_stdata;
      if (memwb_wr) rf[memwb_rd] <= memwb_data;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.wb_valid  = memwb_wr && !bus.hold;
  assign bus.wb_rd     = memwb_rd;
  assign bus.wb_data   = memwb_data;
  assign bus.stall     = stall;
endmodule
